// File: rtl/des_round_key_scheduler_if.sv
// Round-key handshake bus between the subkey scheduler (master) and the DES round datapath (slave).
interface des_round_key_scheduler_if;
  logic [47:0] rk_data;
  logic        rk_valid;
  logic        rk_ready;
  logic [4:0]  rk_round;
  logic        rk_last;

  modport master (output rk_data, rk_valid, rk_round, rk_last, input rk_ready);
  modport slave  (input rk_data, rk_valid, rk_round, rk_last, output rk_ready);
endinterface

// File: rtl/des_round_key_scheduler.sv
// Steps a combinational DES subkey generator through 16 rounds and issues registered subkeys.
// First subkey valid 2 cycles after start, one per 2 cycles; rk_ready low holds the subkey indefinitely.
module des_round_key_scheduler #(
  parameter int NUM_ROUNDS = 16,
  parameter int KEYID_W    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_i,
  input  logic                      mode_i,
  input  logic [63:0]               key_i,
  input  logic                      abort_i,
  output logic [63:0]               gen_key_o,
  output logic [KEYID_W-1:0]        gen_keyid_o,
  input  logic [47:0]               gen_subkey_i,
  des_round_key_scheduler_if.master rk_if,
  output logic                      busy_o,
  output logic                      done_o
);

  if (NUM_ROUNDS != 16) begin : g_bad_rounds
    $error("des_round_key_scheduler supports only NUM_ROUNDS == 16");
  end
  if (KEYID_W != 4) begin : g_bad_keyid
    $error("des_round_key_scheduler supports only KEYID_W == 4");
  end

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] ISSUE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [4:0] LAST_R = 5'd16;

  logic [1:0]         state_q, state_d;
  logic [4:0]         r_q, r_d;
  logic               mode_q, mode_d;
  logic [63:0]        key_q, key_d;
  logic [KEYID_W-1:0] keyid_q, keyid_d;
  logic [47:0]        data_q, data_d;
  logic               valid_q, valid_d;
  logic [4:0]         round_q, round_d;
  logic               last_q, last_d;

  // Generator round select: round 16 is encoded as zero.
  function automatic logic [KEYID_W-1:0] round_code(input logic [4:0] k);
    return (k == LAST_R) ? '0 : k[KEYID_W-1:0];
  endfunction

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    mode_d  = mode_q;
    key_d   = key_q;
    keyid_d = keyid_q;
    data_d  = data_q;
    valid_d = valid_q;
    round_d = round_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (start_i && !abort_i) begin
          key_d   = key_i;
          mode_d  = mode_i;
          r_d     = 5'd1;
          keyid_d = round_code(mode_i ? LAST_R : 5'd1);
          state_d = LOAD;
        end
      end
      LOAD: begin
        data_d  = gen_subkey_i;
        round_d = r_q;
        last_d  = (r_q == LAST_R);
        valid_d = 1'b1;
        state_d = ISSUE;
      end
      ISSUE: begin
        if (valid_q && rk_if.rk_ready) begin
          valid_d = 1'b0;
          if (r_q < LAST_R) begin
            r_d     = r_q + 5'd1;
            // Decrypt walks the generator downwards: next round k = 17-(r+1).
            keyid_d = round_code(mode_q ? (LAST_R - r_q) : (r_q + 5'd1));
            state_d = LOAD;
          end else begin
            last_d  = 1'b0;
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort_i && (state_q != IDLE)) begin
      state_d = IDLE;
      valid_d = 1'b0;
      last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      r_q     <= '0;
      mode_q  <= 1'b0;
      key_q   <= '0;
      keyid_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      round_q <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      mode_q  <= mode_d;
      key_q   <= key_d;
      keyid_q <= keyid_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      round_q <= round_d;
      last_q  <= last_d;
    end
  end

  assign gen_key_o      = key_q;
  assign gen_keyid_o    = keyid_q;
  assign rk_if.rk_data  = data_q;
  assign rk_if.rk_valid = valid_q;
  assign rk_if.rk_round = round_q;
  assign rk_if.rk_last  = last_q;
  assign busy_o         = (state_q != IDLE);
  // An abort landing in the DONE cycle suppresses the pulse.
  assign done_o         = (state_q == DONE) && !abort_i;

endmodule

// File: tb/tb_des_round_key_scheduler.sv
// Bench for des_round_key_scheduler: behavioural DES key generator plus a per-round schedule model.
module tb_des_round_key_scheduler;
  logic        clk = 1'b0;
  logic        rst, start, mode, abort;
  logic [63:0] key, gen_key;
  logic [3:0]  gen_keyid;
  logic [47:0] gen_subkey;
  logic        busy, done;
  int          checks = 0;
  int          errors = 0;

  des_round_key_scheduler_if rk_if();

  des_round_key_scheduler #(.NUM_ROUNDS(16), .KEYID_W(4)) dut (
    .clk(clk), .rst(rst), .start_i(start), .mode_i(mode), .key_i(key), .abort_i(abort),
    .gen_key_o(gen_key), .gen_keyid_o(gen_keyid), .gen_subkey_i(gen_subkey),
    .rk_if(rk_if), .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  int pc1_t[56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,
                    60,52,44,36,63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,
                    29,21,13,5,28,20,12,4};
  int pc2_t[48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                    41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
  int sh_t[16]  = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

  logic [47:0] sched [1:16];

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] cd;
    for (int i = 0; i < 56; i++) cd[55-i] = k[64-pc1_t[i]];
    return cd;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] s;
    for (int j = 0; j < 48; j++) s[47-j] = cd[56-pc2_t[j]];
    return s;
  endfunction

  function automatic logic [27:0] rotl28(input logic [27:0] v, input int n);
    logic [27:0] t;
    t = v;
    for (int i = 0; i < n; i++) t = {t[26:0], t[27]};
    return t;
  endfunction

  // Stand-in for the combinational generator: cumulative shift for the selected round.
  function automatic logic [47:0] gen_model(input logic [63:0] k, input logic [3:0] id);
    logic [55:0] cd;
    int rnd, tot;
    rnd = (id == 4'd0) ? 16 : int'(id);
    tot = 0;
    for (int i = 0; i < rnd; i++) tot += sh_t[i];
    cd = pc1(k);
    return pc2({rotl28(cd[55:28], tot), rotl28(cd[27:0], tot)});
  endfunction

  assign gen_subkey = gen_model(gen_key, gen_keyid);

  // Reference schedule: iterate the C/D halves round by round.
  task automatic build_sched(input logic [63:0] k);
    logic [27:0] c, d;
    logic [55:0] cd;
    cd = pc1(k);
    c = cd[55:28];
    d = cd[27:0];
    for (int i = 1; i <= 16; i++) begin
      c = rotl28(c, sh_t[i-1]);
      d = rotl28(d, sh_t[i-1]);
      sched[i] = pc2({c, d});
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, 64'(rk_if.rk_valid), 64'd0);
    chk({tag, "_data"},  64'(rk_if.rk_data),  64'd0);
    chk({tag, "_round"}, 64'(rk_if.rk_round), 64'd0);
    chk({tag, "_last"},  64'(rk_if.rk_last),  64'd0);
    chk({tag, "_key"},   gen_key,             64'd0);
    chk({tag, "_keyid"}, 64'(gen_keyid),      64'd0);
    chk({tag, "_busy"},  64'(busy),           64'd0);
    chk({tag, "_done"},  64'(done),           64'd0);
  endtask

  // Runs one schedule from IDLE, starting and ending at a negedge.
  task automatic run(input logic [63:0] k, input logic m, input int ready_pct,
                     input int stall_rnd, input int stall_len, input int start_rnd,
                     input int abort_rnd, input int rst_rnd,
                     output logic [47:0] first_d, output logic [47:0] last_d,
                     output logic [3:0] first_id, output logic [3:0] last_id);
    int nr, edges, stalls, expk;
    logic hs, prev_valid, finished, seen, rdy;
    build_sched(k);
    key = k; mode = m; start = 1'b1; abort = 1'b0; rk_if.rk_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    nr = 1; edges = 0; stalls = 0; hs = 0; prev_valid = 0; finished = 0; seen = 0;
    first_d = '0; last_d = '0; first_id = '0; last_id = '0;
    for (int it = 0; it < 600 && !finished; it++) begin
      key = {$urandom, $urandom}; mode = 1'($urandom); start = 1'b0; abort = 1'b0;
      if (nr > 16) begin
        chk("done_pulse", 64'(done), 64'd1);
        chk("done_busy", 64'(busy), 64'd1);
        chk("done_valid", 64'(rk_if.rk_valid), 64'd0);
        chk("done_last", 64'(rk_if.rk_last), 64'd0);
        if (ready_pct == 100) chk("done_latency", 64'(edges), 64'(32 + stall_len));
        start = 1'b1;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        chk("done_single_cycle", 64'(done), 64'd0);
        chk("start_in_done_ignored", 64'(busy), 64'd0);
        finished = 1;
      end else begin
        chk("done_early", 64'(done), 64'd0);
        chk("busy_in_schedule", 64'(busy), 64'd1);
        chk("gen_key_held", gen_key, k);
        if (hs) chk("valid_drops_after_hs", 64'(rk_if.rk_valid), 64'd0);
        if (prev_valid && !hs) chk("valid_held", 64'(rk_if.rk_valid), 64'd1);
        rdy = 1'($urandom_range(0, 1));
        if (rk_if.rk_valid) begin
          expk = m ? 17 - nr : nr;
          if (!seen) begin
            chk("first_valid_latency", 64'(edges), 64'd1);
            first_d = rk_if.rk_data; first_id = gen_keyid; seen = 1;
          end
          last_d = rk_if.rk_data; last_id = gen_keyid;
          chk("rk_round", 64'(rk_if.rk_round), 64'(nr));
          chk("rk_data", 64'(rk_if.rk_data), 64'(sched[expk]));
          chk("rk_last", 64'(rk_if.rk_last), 64'(nr == 16));
          chk("gen_keyid", 64'(gen_keyid), 64'(expk % 16));
          rdy = ($urandom_range(0, 99) < ready_pct);
          if (nr == stall_rnd && stalls < stall_len) begin rdy = 1'b0; stalls++; end
          if (nr == start_rnd) start = 1'b1;
          if (nr == abort_rnd) begin abort = 1'b1; rdy = 1'b1; end
        end
        rk_if.rk_ready = rdy;
        prev_valid = rk_if.rk_valid;
        hs = rk_if.rk_valid && rdy;
        if (rk_if.rk_valid && nr == rst_rnd) begin
          #2 rst = 1'b1;
          #1 chk_all_zero("async_rst");
          @(negedge clk);
          rst = 1'b0;
          finished = 1;
        end else begin
          @(posedge clk); @(negedge clk);
          edges++;
          if (abort) begin
            abort = 1'b0;
            chk("abort_valid", 64'(rk_if.rk_valid), 64'd0);
            chk("abort_last", 64'(rk_if.rk_last), 64'd0);
            chk("abort_busy", 64'(busy), 64'd0);
            for (int j = 0; j < 3; j++) begin
              chk("abort_no_done", 64'(done), 64'd0);
              @(posedge clk); @(negedge clk);
            end
            finished = 1;
          end else if (hs) begin
            nr++;
          end
        end
      end
    end
    chk("schedule_terminated", 64'(finished), 64'd1);
    start = 1'b0; abort = 1'b0; rk_if.rk_ready = 1'b0;
  endtask

  localparam logic [63:0] KAT_KEY = 64'h133457799BBCDFF1;

  initial begin
    logic [47:0] fd, ld;
    logic [3:0]  fi, li;
    logic [63:0] rk;
    rst = 1'b1; start = 1'b0; mode = 1'b0; key = '0; abort = 1'b0; rk_if.rk_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // abort beats start in IDLE; abort alone in IDLE does nothing
    abort = 1'b1; start = 1'b1; key = {$urandom, $urandom};
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    chk("idle_abort_start_busy", 64'(busy), 64'd0);
    chk("idle_abort_start_key", gen_key, 64'd0);
    @(posedge clk); @(negedge clk);
    abort = 1'b0;
    chk("idle_abort_busy", 64'(busy), 64'd0);

    run(KAT_KEY, 1'b0, 100, 0, 0, 0, 0, 0, fd, ld, fi, li);
    chk("enc_first_data", 64'(fd), 64'h1B02EFFC7072);
    chk("enc_first_keyid", 64'(fi), 64'd1);
    chk("enc_last_data", 64'(ld), 64'hCB3D8B0E17F5);
    chk("enc_last_keyid", 64'(li), 64'd0);

    run(KAT_KEY, 1'b1, 100, 0, 0, 0, 0, 0, fd, ld, fi, li);
    chk("dec_first_data", 64'(fd), 64'hCB3D8B0E17F5);
    chk("dec_first_keyid", 64'(fi), 64'd0);
    chk("dec_last_data", 64'(ld), 64'h1B02EFFC7072);
    chk("dec_last_keyid", 64'(li), 64'd1);

    rk = {$urandom, $urandom};
    run(rk, 1'($urandom), 100, 3, 5, 0, 0, 0, fd, ld, fi, li);
    rk = {$urandom, $urandom};
    run(rk, 1'($urandom), 100, 0, 0, 7, 0, 0, fd, ld, fi, li);
    rk = {$urandom, $urandom};
    run(rk, 1'b0, 100, 0, 0, 0, 5, 0, fd, ld, fi, li);
    run(rk, 1'b1, 100, 0, 0, 0, 0, 0, fd, ld, fi, li);
    rk = {$urandom, $urandom};
    run(rk, 1'b0, 100, 0, 0, 0, 0, 10, fd, ld, fi, li);
    run(rk, 1'b0, 100, 0, 0, 0, 0, 0, fd, ld, fi, li);
    for (int n = 0; n < 4; n++) begin
      rk = {$urandom, $urandom};
      run(rk, 1'($urandom), 60, 0, 0, 0, 0, 0, fd, ld, fi, li);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/des_round_key_scheduler.md
Name: des_round_key_scheduler

Overview:
- Sequencer for the combinational DES subkey generator.
- Latches a 64-bit key on start and steps the generator's round-select input through the 16 rounds: ascending for encryption, descending for decryption.
- Registers each 48-bit subkey and hands it to the DES round datapath over a valid/ready handshake, one subkey per round, with round index and last-round flag.
- Sits between the host/control wrapper and the round datapath; owns the generator's key and keyid inputs exclusively.

Parameters:
- NUM_ROUNDS, 16, rounds per block; only 16 is supported, with an elaboration-time check.
- KEYID_W, 4, width of the generator round-select bus.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  pulse; accepted only in IDLE
- mode  in  1  0 = encrypt (rounds 1..16), 1 = decrypt (rounds 16..1); sampled with start
- key_in  in  64  DES key, bit 1 = MSB; sampled with start
- abort  in  1  cancel current schedule
- gen_key  out  64  latched key driven to the subkey generator
- gen_keyid  out  4  round select to the generator; round k encoded as k, except round 16 encoded 4'd0
- gen_subkey  in  48  combinational subkey returned by the generator
- rk_data  out  48  registered subkey
- rk_valid  out  1  rk_data valid
- rk_ready  in  1  datapath accepts rk_data
- rk_round  out  5  round number 1..16 of rk_data (datapath order, always ascending)
- rk_last  out  1  high with the 16th subkey
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse after the 16th handshake

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0. This covers gen_key, gen_keyid, rk_data, rk_valid, rk_round, rk_last, busy and done.
- States: IDLE, LOAD, ISSUE, DONE.
- IDLE, start=1:
  - latch key_in into gen_key and mode into mode_r
  - set counter r=1
  - drive gen_keyid = code(k), where k = r (enc) or 17-r (dec) and code(16)=0
  - go to LOAD
- IDLE, start=0: no change. rk_data holds its last value; rk_valid=0.
- LOAD (one cycle, lets the generator settle):
  - rk_data <= gen_subkey, rk_round <= r, rk_last <= (r==16), rk_valid <= 1
  - go to ISSUE
- ISSUE:
  - rk_valid=1; rk_data, rk_round and rk_last are held stable while rk_ready=0 (no timeout).
  - On rk_valid & rk_ready with r<16: r <= r+1, gen_keyid updates to the next code, rk_valid <= 0, go to LOAD.
  - On handshake with r==16: rk_valid <= 0, rk_last <= 0, go to DONE.
- DONE: done=1 for exactly one cycle; go to IDLE.
- Throughput: one subkey per 2 cycles with rk_ready tied high. start to first rk_valid = 2 cycles; 16-round schedule = 33 cycles from start to done.
- gen_key and mode_r are held constant from start until return to IDLE; key_in/mode changes mid-schedule are ignored.
- start while busy: ignored. No queuing; a start coincident with the DONE cycle is ignored.
- abort in LOAD/ISSUE/DONE:
  - next state IDLE; rk_valid, rk_last and done forced 0; done never pulses.
  - abort coincident with a handshake: abort wins, and the accepted subkey is the last one delivered.
  - abort in IDLE has no effect; abort and start together in IDLE: abort wins, start ignored.
- Counter wrap: r never exceeds 16; no wrap to 0 can occur.
- Reset asserted mid-schedule: immediate return to reset values; rk_valid drops asynchronously.

Test Plan:
- Encrypt: key 0x133457799BBCDFF1, mode=0, rk_ready=1, standard generator attached -> 16 handshakes. Round 1 gives rk_round=1, gen_keyid=1, rk_data=0x1B02EFFC7072. Round 16 gives gen_keyid=0, rk_data=0xCB3D8B0E17F5, rk_last=1. done pulses 33 cycles after start.
- Decrypt, same key, mode=1 -> first rk_data=0xCB3D8B0E17F5 with rk_round=1, gen_keyid=0; last rk_data=0x1B02EFFC7072 with rk_round=16, rk_last=1.
- Backpressure: rk_ready=0 for 5 cycles at round 3 -> rk_valid stays 1, rk_data/rk_round=3 stable; exactly 16 subkeys total, no duplicates or skips.
- start pulsed at round 7 with a different key/mode -> ignored, schedule completes with the original key; busy=1 throughout.
- abort asserted during ISSUE of round 5, same cycle as rk_ready=1 -> next cycle IDLE, rk_valid=0, busy=0, no done. A new start then begins cleanly at round 1.
- rst pulsed asynchronously at round 10 -> all outputs 0 before the next clock edge; a subsequent start runs a full 16-round schedule.
